// File: rtl/apu_pkg.sv
// +---------------------------------------------------------------+
// | apu_pkg: shared APU constants (length table, register map)    |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

package apu_pkg;

  localparam logic [1:0] ADDR_TRI_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TRI_TLO  = 2'd2;
  localparam logic [1:0] ADDR_TRI_THI  = 2'd3;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tri_linear_counter.sv
// +---------------------------------------------------------------+
// | tri_linear_counter: triangle linear counter + reload flag     |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module tri_linear_counter
  import apu_pkg::*;
#(
  parameter int LIN_WIDTH = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 quarter_frame_i,
  input  logic                 ctrl_flag_i,
  input  logic [LIN_WIDTH-1:0] lin_reload_i,
  input  logic                 reload_set_i,
  output logic [LIN_WIDTH-1:0] linear_o
);

  logic [LIN_WIDTH-1:0] linear_q, linear_d;
  logic                 reload_q, reload_d;
  logic                 reload_eff;

  // A same-cycle length/tone-high write must already count as a pending reload.
  assign reload_eff = reload_q | reload_set_i;

  always_comb begin
    linear_d = linear_q;
    reload_d = reload_eff;
    if (quarter_frame_i) begin
      if (reload_eff) begin
        linear_d = lin_reload_i;
      end else if (linear_q != '0) begin
        linear_d = linear_q - 1'b1;
      end
      if (!ctrl_flag_i) begin
        reload_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      linear_q <= '0;
      reload_q <= 1'b0;
    end else begin
      linear_q <= linear_d;
      reload_q <= reload_d;
    end
  end

  assign linear_o = linear_q;

endmodule

`default_nettype wire

// File: rtl/triangle_channel_ctrl.sv
// +---------------------------------------------------------------+
// | triangle_channel_ctrl: triangle voice registers, length/linear|
// | counters and phase-step gating. Rev 1.0                       |
// +---------------------------------------------------------------+
`default_nettype none

module triangle_channel_ctrl
  import apu_pkg::*;
#(
  parameter int TONE_WIDTH = 10,
  parameter int LIN_WIDTH  = 7,
  parameter int MIN_TONE   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  wr_en_in,
  input  logic [1:0]            wr_addr_in,
  input  logic [7:0]            wr_data_in,
  input  logic                  enable_in,
  input  logic                  quarter_frame_in,
  input  logic                  half_frame_in,
  input  logic                  step_in,
  output logic [TONE_WIDTH-1:0] tone_out,
  output logic                  step_out,
  output logic                  active_out
);

  logic                  ctrl_q, ctrl_d;
  logic [LIN_WIDTH-1:0]  lin_reload_q, lin_reload_d;
  logic [TONE_WIDTH-1:0] tone_q, tone_d;
  logic [7:0]            length_q, length_d;
  logic                  step_q, step_d;
  logic                  active_q;
  logic [LIN_WIDTH-1:0]  linear;
  logic                  wr_ctrl, wr_tlo, wr_thi;

  assign wr_ctrl = wr_en_in && (wr_addr_in == ADDR_TRI_CTRL);
  assign wr_tlo  = wr_en_in && (wr_addr_in == ADDR_TRI_TLO);
  assign wr_thi  = wr_en_in && (wr_addr_in == ADDR_TRI_THI);

  always_comb begin
    ctrl_d       = ctrl_q;
    lin_reload_d = lin_reload_q;
    tone_d       = tone_q;
    if (wr_ctrl) begin
      ctrl_d       = wr_data_in[7];
      lin_reload_d = wr_data_in[LIN_WIDTH-1:0];
    end
    if (wr_tlo) begin
      tone_d[7:0] = wr_data_in;
    end
    if (wr_thi) begin
      tone_d[9:8] = wr_data_in[1:0];
    end
  end

  // Load beats a same-cycle half-frame decrement; frame logic sees pre-write ctrl.
  always_comb begin
    length_d = length_q;
    if (!enable_in) begin
      length_d = '0;
    end else if (wr_thi) begin
      length_d = len_lookup(wr_data_in[7:3]);
    end else if (half_frame_in && (length_q != '0) && !ctrl_q) begin
      length_d = length_q - 8'd1;
    end
  end

  tri_linear_counter #(
    .LIN_WIDTH (LIN_WIDTH)
  ) u_linear (
    .clk_i           (clk_in),
    .rst_ni          (rst_n_in),
    .quarter_frame_i (quarter_frame_in),
    .ctrl_flag_i     (ctrl_q),
    .lin_reload_i    (lin_reload_q),
    .reload_set_i    (wr_thi),
    .linear_o        (linear)
  );

  assign step_d = step_in && (length_q != '0) && (linear != '0)
                  && (tone_q >= TONE_WIDTH'(MIN_TONE));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ctrl_q       <= 1'b0;
      lin_reload_q <= '0;
      tone_q       <= '0;
      length_q     <= '0;
      step_q       <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      lin_reload_q <= lin_reload_d;
      tone_q       <= tone_d;
      length_q     <= length_d;
      step_q       <= step_d;
      active_q     <= (length_d != '0);
    end
  end

  assign tone_out   = tone_q;
  assign step_out   = step_q;
  assign active_out = active_q;

endmodule

`default_nettype wire

// File: tb/tb_triangle_channel_ctrl.sv
// +---------------------------------------------------------------+
// | tb_triangle_channel_ctrl: scoreboard bench for the triangle   |
// | channel sequencer. Rev 1.0                                    |
// +---------------------------------------------------------------+
`default_nettype none

module tb_triangle_channel_ctrl;
  import apu_pkg::*;

  logic       clk_in;
  logic       rst_n_in;
  logic       wr_en_in;
  logic [1:0] wr_addr_in;
  logic [7:0] wr_data_in;
  logic       enable_in;
  logic       quarter_frame_in;
  logic       half_frame_in;
  logic       step_in;
  logic [9:0] tone_out;
  logic       step_out;
  logic       active_out;

  triangle_channel_ctrl #(
    .TONE_WIDTH (10),
    .LIN_WIDTH  (7),
    .MIN_TONE   (2)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .wr_en_in         (wr_en_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .enable_in        (enable_in),
    .quarter_frame_in (quarter_frame_in),
    .half_frame_in    (half_frame_in),
    .step_in          (step_in),
    .tone_out         (tone_out),
    .step_out         (step_out),
    .active_out       (active_out)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] tone;
    logic       step;
    logic       active;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_check = 0;
  bit   step_seen;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  // Monitor: pops every expectation due this cycle, and flags any step pulse
  // that no stimulus asked for.
  always @(negedge clk_in) begin
    step_seen = 1'b0;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_check++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: expectation for cycle %0d sampled at cycle %0d", e.name, e.cyc, cyc);
      end else if (tone_out === e.tone && step_out === e.step && active_out === e.active) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got tone=%h step=%b active=%b, want tone=%h step=%b active=%b",
                 e.name, tone_out, step_out, active_out, e.tone, e.step, e.active);
      end
      if (e.step) step_seen = 1'b1;
    end
    if (step_out === 1'b1 && !step_seen) begin
      n_check++;
      $display("FAIL unexpected_step: got step=1 at cycle %0d, want step=0", cyc);
    end
  end

  task automatic drive(input logic we, input logic [1:0] a, input logic [7:0] d,
                       input logic qf, input logic hf, input logic st);
    wr_en_in         = we;
    wr_addr_in       = a;
    wr_data_in       = d;
    quarter_frame_in = qf;
    half_frame_in    = hf;
    step_in          = st;
    @(posedge clk_in);
    #1;
    wr_en_in         = 1'b0;
    quarter_frame_in = 1'b0;
    half_frame_in    = 1'b0;
    step_in          = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic qf();
    drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hf();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic st();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [9:0] t, input logic s, input logic act);
    sb.push_back('{cyc, nm, t, s, act});
  endtask

  initial begin
    rst_n_in = 1'b0; enable_in = 1'b0; wr_en_in = 1'b0; wr_addr_in = 2'd0;
    wr_data_in = 8'h00; quarter_frame_in = 1'b0; half_frame_in = 1'b0; step_in = 1'b0;

    idle();                      chk("reset_hold", 10'h000, 1'b0, 1'b0);
    st();                        chk("reset_step", 10'h000, 1'b0, 1'b0);
    rst_n_in = 1'b1;
    idle();                      chk("post_reset", 10'h000, 1'b0, 1'b0);

    // Basic gating
    enable_in = 1'b1;
    wr(ADDR_TRI_CTRL, 8'h85);    chk("wr_ctrl", 10'h000, 1'b0, 1'b0);
    wr(ADDR_TRI_TLO, 8'h40);     chk("wr_tlo", 10'h040, 1'b0, 1'b0);
    wr(ADDR_TRI_THI, 8'h09);     chk("wr_thi_load", 10'h140, 1'b0, 1'b1);
    qf();                        chk("qf_reload", 10'h140, 1'b0, 1'b1);
    st();                        chk("step_pass", 10'h140, 1'b1, 1'b1);
    idle();                      chk("step_one_cycle", 10'h140, 1'b0, 1'b1);

    // Linear expiry: reload 3 then count 3,2,1,0
    wr(ADDR_TRI_CTRL, 8'h03);
    wr(ADDR_TRI_THI, 8'h09);     chk("reload_254", 10'h140, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) qf();
    st();                        chk("step_lin1", 10'h140, 1'b1, 1'b1);
    qf();
    st();                        chk("lin_expired", 10'h140, 1'b0, 1'b1);
    qf();
    st();                        chk("lin_stays0", 10'h140, 1'b0, 1'b1);
    hf();                        chk("len_after_hf", 10'h140, 1'b0, 1'b1);

    // Length halt then decrement to floor
    wr(ADDR_TRI_CTRL, 8'h80);
    wr(ADDR_TRI_THI, 8'h00);     chk("len10", 10'h040, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      hf();                      chk("len_halted", 10'h040, 1'b0, 1'b1);
    end
    wr(ADDR_TRI_CTRL, 8'h00);
    for (int i = 0; i < 10; i++) begin
      hf();                      chk("len_dec", 10'h040, 1'b0, (i < 9));
    end
    hf();                        chk("len_floor", 10'h040, 1'b0, 1'b0);

    // Collisions
    drive(1'b1, ADDR_TRI_THI, 8'h18, 1'b0, 1'b1, 1'b0);
                                 chk("coll_hf_load", 10'h040, 1'b0, 1'b1);
    hf();                        chk("coll_hf_len1", 10'h040, 1'b0, 1'b1);
    hf();                        chk("coll_hf_len0", 10'h040, 1'b0, 1'b0);
    wr(ADDR_TRI_CTRL, 8'h04);
    for (int i = 0; i < 5; i++) qf();
    drive(1'b1, ADDR_TRI_THI, 8'h18, 1'b1, 1'b0, 1'b0);
                                 chk("coll_qf", 10'h040, 1'b0, 1'b1);
    st();                        chk("coll_qf_step", 10'h040, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) qf();
    st();                        chk("flag_cleared", 10'h040, 1'b0, 1'b1);

    // Disable and ultrasonic guard
    enable_in = 1'b0;
    idle();                      chk("disable_clr", 10'h040, 1'b0, 1'b0);
    wr(ADDR_TRI_THI, 8'h18);     chk("disable_noload", 10'h040, 1'b0, 1'b0);
    enable_in = 1'b1;
    wr(ADDR_TRI_THI, 8'h18);     chk("reenable_load", 10'h040, 1'b0, 1'b1);
    wr(ADDR_TRI_CTRL, 8'h85);
    qf();
    wr(ADDR_TRI_TLO, 8'h01);     chk("tone1", 10'h001, 1'b0, 1'b1);
    st();                        chk("ultrasonic_mute", 10'h001, 1'b0, 1'b1);
    wr(ADDR_TRI_TLO, 8'h02);
    st();                        chk("tone2_pass", 10'h002, 1'b1, 1'b1);

    // Reset mid-stream with length 10, linear 5
    wr(ADDR_TRI_THI, 8'h00);     chk("len10_again", 10'h002, 1'b0, 1'b1);
    qf();
    st();                        chk("pre_reset_step", 10'h002, 1'b1, 1'b1);
    st();
    #1;
    rst_n_in = 1'b0;             chk("async_reset", 10'h000, 1'b0, 1'b0);
    @(posedge clk_in);
    #1;                          chk("reset_held", 10'h000, 1'b0, 1'b0);
    rst_n_in = 1'b1;
    st();                        chk("post_reset_step", 10'h000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle();

    n_check++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/triangle_channel_ctrl.md
Name: triangle_channel_ctrl

Overview:
- APU-style sequencer for one triangle voice. It holds the channel's register file (tone, linear-counter reload, length index, halt/control flag) and runs the length counter and linear counter from frame-sequencer ticks.
- It gates the sample-rate step pulse that advances the triangle generator's phase accumulator. Waveform silencing therefore freezes phase and does not zero the output.
- It sits between the CPU-side register bus and triangle_generator, and drives that generator's tone_in and step_in.

Parameters:
TONE_WIDTH, 10, width of tone/period word driven to the generator
LIN_WIDTH, 7, width of linear counter and its reload value
MIN_TONE, 2, tone values below this mute stepping (ultrasonic guard)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
wr_en_in  input  1  single-cycle register write strobe
wr_addr_in  input  2  register select: 0 ctrl/linear, 1 unused, 2 tone low, 3 length/tone high
wr_data_in  input  8  write data
enable_in  input  1  channel enable (status-register bit)
quarter_frame_in  input  1  single-cycle quarter-frame tick
half_frame_in  input  1  single-cycle half-frame tick
step_in  input  1  sample-rate phase-step tick
tone_out  output  TONE_WIDTH  tone word to generator
step_out  output  1  gated phase-step tick to generator
active_out  output  1  length counter nonzero

Behaviour:
- Reset (async, rst_n_in low): all registers 0. Outputs: tone_out=0, step_out=0, active_out=0. Reload flag cleared. Deassertion takes effect on the next clk_in edge.
- Register writes (wr_en_in=1, sampled on clk_in):
  - addr 0: ctrl_flag<=data[7]; lin_reload<=data[6:0].
  - addr 1: ignored.
  - addr 2: tone[7:0]<=data.
  - addr 3: tone[9:8]<=data[1:0]; reload_flag<=1; if enable_in, then length<=LEN_TABLE[data[7:3]].
- ctrl_flag does double duty: it halts the length counter and holds the linear reload flag.
- Length counter (8 bit):
  - enable_in low: cleared to 0 every cycle. Writes to addr 3 do not load it.
  - On half_frame_in: if length!=0 and ctrl_flag=0, decrement.
  - Never wraps below 0.
- Linear counter (LIN_WIDTH) on quarter_frame_in:
  - If reload_flag: linear<=lin_reload.
  - Else if linear!=0: decrement.
  - Then, if ctrl_flag=0: reload_flag<=0.
- Simultaneous events:
  - addr-3 write + half_frame same cycle: the load wins; no decrement that cycle.
  - addr-3 write + quarter_frame same cycle: the quarter-frame action sees reload_flag=1, so linear<=lin_reload. reload_flag stays 1 if ctrl_flag=1, else it clears.
  - addr-0 write + quarter/half_frame same cycle: frame logic uses the pre-write ctrl_flag and lin_reload.
  - enable_in low + addr-3 write same cycle: length stays 0.
- Gating (registered, 1-cycle latency): step_out<=step_in & (length!=0) & (linear!=0) & (tone>=MIN_TONE).
  - The counter values are those held before the current edge.
  - step_out is never high two consecutive cycles unless step_in was.
- tone_out is a direct register output and updates the cycle after the write.
- active_out is registered: active_out<=(next length!=0).
- Mid-operation reset clears counters immediately; step_out drops asynchronously.

Decomposition:
- Shared package (apu_pkg): LEN_TABLE, 32 x 8-bit constant = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Same package: register address constants ADDR_TRI_CTRL=0, ADDR_TRI_TLO=2, ADDR_TRI_THI=3.
- One natural sub-module: tri_linear_counter, containing the linear counter, reload flag and quarter-frame logic.
- Length counter and gating remain in the top.

Test Plan:
- Reset mid-stream: with length=10 and linear=5, pulse rst_n_in low → tone_out=0, step_out=0 and active_out=0 immediately. The next step_in gives step_out=0.
- Basic gating, in order:
  - enable=1; write addr0=0x85 (ctrl=1, reload=5), addr2=0x40, addr3=0x09 (index 1 → length 254, tone[9:8]=01 → tone 0x140).
  - One quarter_frame → linear=5; active_out=1.
  - step_in pulse → step_out high exactly 1 cycle later.
- Linear expiry:
  - addr0=0x03 (ctrl=0, reload 3), then addr3 write.
  - 4 quarter_frames give linear 3,2,1,0.
  - Once linear=0, step_in pulses produce no step_out; length is unchanged until a half-frame.
- Length halt/decrement:
  - Index 0 (length 10), ctrl=1: 12 half_frames → length stays 10.
  - Then ctrl=0: 10 half_frames → active_out=0 after the 10th. An 11th half_frame keeps length 0.
- Collision: addr-3 write (index 3 → length 2) in the same cycle as half_frame → length=2, not 1. A write in the same cycle as quarter_frame → linear=lin_reload.
- Disable/ultrasonic:
  - enable_in=0 → length 0 next cycle; an addr-3 write does not load.
  - With enable=1 and tone=1, counters nonzero: step_in → step_out=0.
  - tone=2 → step_out passes.
